// File: rtl/fp16_pkg.sv
// Shared FP16 constants and the divider FSM state type.
package fp16_pkg;
   localparam int MANT_W  = 11;
   localparam int EXP_W   = 5;
   localparam int BIAS    = 15;
   localparam int EXP_MAX = 31;
   localparam int HIDDEN  = 1024;
   localparam int QBITS   = 13;
   localparam int EDIFF_W = 7;

   localparam logic signed [EDIFF_W-1:0] EMAX_S = EDIFF_W'(EXP_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIV   = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/fp16_round_ne.sv
// Combinational quotient normalizer: round-to-nearest-even, exponent bias/adjust, saturate or flush.
module fp16_round_ne
   import fp16_pkg::*;
(
   input  logic [QBITS-1:0]          i_q,
   input  logic                      i_rem_nz,
   input  logic signed [EDIFF_W-1:0] i_ediff,
   output logic [MANT_W-1:0]         o_mant,
   output logic [EXP_W-1:0]          o_exp,
   output logic                      o_ovf,
   output logic                      o_unf
);
   logic [MANT_W-1:0]         w_mant;
   logic                      w_guard;
   logic                      w_sticky;
   logic                      w_up;
   logic [MANT_W:0]           w_sum;
   logic signed [EDIFF_W-1:0] w_eadj;
   logic signed [EDIFF_W-1:0] w_e;

   always_comb begin
      w_mant   = i_q[QBITS-1] ? i_q[QBITS-1:2] : i_q[QBITS-2:1];
      w_guard  = i_q[QBITS-1] ? i_q[1] : i_q[0];
      w_sticky = (i_q[QBITS-1] & i_q[0]) | i_rem_nz;
      w_up     = w_guard & (w_sticky | w_mant[0]);
      w_sum    = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_up};
      // A quotient below 1.0 was shifted one place further, so the exponent drops by one.
      w_eadj   = i_q[QBITS-1] ? 7'sd0 : -7'sd1;
      if (w_sum[MANT_W])
         w_eadj = w_eadj + 7'sd1;
      w_e      = i_ediff + w_eadj;

      o_ovf  = 1'b0;
      o_unf  = 1'b0;
      o_exp  = w_e[EXP_W-1:0];
      o_mant = w_sum[MANT_W] ? MANT_W'(HIDDEN) : w_sum[MANT_W-1:0];
      if (w_e >= EMAX_S) begin
         o_ovf  = 1'b1;
         o_exp  = EXP_W'(EXP_MAX);
         o_mant = MANT_W'(HIDDEN);
      end else if (w_e <= 7'sd0) begin
         o_unf  = 1'b1;
         o_exp  = '0;
         o_mant = '0;
      end
   end
endmodule

// File: rtl/fpdu.sv
// Sequential FP16 divider: restoring mantissa divide, one quotient bit per cycle, then RNE round.
// Latency: done 15 cycles after accept (1 for zero operands); start ignored while busy, no queueing.
module fpdu
   import fp16_pkg::*;
(
   input  logic              clk_alu,
   input  logic              rst_alu_n,
   input  logic              start,
   input  logic [MANT_W-1:0] operand_a_mant,
   input  logic [MANT_W-1:0] operand_b_mant,
   input  logic [EXP_W-1:0]  operand_a_exp,
   input  logic [EXP_W-1:0]  operand_b_exp,
   input  logic              operand_a_sign,
   input  logic              operand_b_sign,
   output logic              busy,
   output logic              done,
   output logic [MANT_W-1:0] result_mant,
   output logic [EXP_W-1:0]  result_exp,
   output logic              result_sign,
   output logic              div_by_zero,
   output logic              overflow,
   output logic              underflow
);
   state_t                    r_state;
   logic [3:0]                r_cnt;
   logic [MANT_W:0]           r_rem;
   logic [MANT_W-1:0]         r_b;
   logic [QBITS-1:0]          r_q;
   logic signed [EDIFF_W-1:0] r_ediff;
   logic [MANT_W-1:0]         r_mant;
   logic [EXP_W-1:0]          r_exp;
   logic                      r_sign;
   logic                      r_dbz;
   logic                      r_ovf;
   logic                      r_unf;

   logic                      w_ge;
   logic [MANT_W:0]           w_step;
   logic [MANT_W-1:0]         w_rnd_mant;
   logic [EXP_W-1:0]          w_rnd_exp;
   logic                      w_rnd_ovf;
   logic                      w_rnd_unf;

   // Remainder stays below twice the divisor, so the left shift never loses a set bit.
   assign w_ge   = (r_rem >= {1'b0, r_b});
   assign w_step = w_ge ? (r_rem - {1'b0, r_b}) : r_rem;

   fp16_round_ne u_round (
      .i_q      (r_q),
      .i_rem_nz (|r_rem),
      .i_ediff  (r_ediff),
      .o_mant   (w_rnd_mant),
      .o_exp    (w_rnd_exp),
      .o_ovf    (w_rnd_ovf),
      .o_unf    (w_rnd_unf)
   );

   always_ff @(posedge clk_alu or negedge rst_alu_n) begin
      if (!rst_alu_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_b     <= '0;
         r_q     <= '0;
         r_ediff <= '0;
         r_mant  <= '0;
         r_exp   <= '0;
         r_sign  <= 1'b0;
         r_dbz   <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_sign  <= operand_a_sign ^ operand_b_sign;
               r_dbz   <= 1'b0;
               r_ovf   <= 1'b0;
               r_unf   <= 1'b0;
               r_rem   <= {1'b0, operand_a_mant};
               r_b     <= operand_b_mant;
               r_q     <= '0;
               r_cnt   <= '0;
               r_ediff <= {2'b00, operand_a_exp} - {2'b00, operand_b_exp} + EDIFF_W'(BIAS);
               if (operand_b_mant == '0) begin
                  r_dbz   <= 1'b1;
                  r_exp   <= EXP_W'(EXP_MAX);
                  r_mant  <= MANT_W'(HIDDEN);
                  r_state <= DONE;
               end else if (operand_a_mant == '0) begin
                  r_exp   <= '0;
                  r_mant  <= '0;
                  r_state <= DONE;
               end else begin
                  r_state <= DIV;
               end
            end
            DIV: begin
               r_q   <= {r_q[QBITS-2:0], w_ge};
               r_rem <= w_step << 1;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'(QBITS - 1))
                  r_state <= ROUND;
            end
            ROUND: begin
               r_mant  <= w_rnd_mant;
               r_exp   <= w_rnd_exp;
               r_ovf   <= w_rnd_ovf;
               r_unf   <= w_rnd_unf;
               r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy        = (r_state != IDLE);
   assign done        = (r_state == DONE);
   assign result_mant = r_mant;
   assign result_exp  = r_exp;
   assign result_sign = r_sign;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ovf;
   assign underflow   = r_unf;
endmodule
